// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed scan controller for a 4-digit common-anode
//               7-segment display. Each digit slot is BLANK_CYC dark cycles
//               followed by SHOW_CYC lit cycles, in digit order 0,1,2,3.
//               A new 4-digit BCD value is captured into a shadow register
//               through a ready/load handshake and transferred to the active
//               (displayed) register only at a frame boundary, so a frame
//               never mixes old and new digits.
//
// Ports       : clk          - clock, all state updates on rising edge
//               rst          - synchronous active-high reset
//               load         - capture digits_in (honoured only when ready)
//               digits_in    - BCD value, [15:12] digit 3 .. [3:0] digit 0
//               lzb          - leading-zero blanking enable
//               ready        - high when a load will be accepted
//               x3..x0       - BCD code to the shared decoder (x3 = MSB)
//               an           - active-low digit enables, an[k] = digit k
//               frame_tick   - one-cycle pulse in the last cycle of a frame
//
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int BLANK_CYC = 2,
    parameter int SHOW_CYC  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic        lzb,
    output logic        ready,
    output logic        x3,
    output logic        x2,
    output logic        x1,
    output logic        x0,
    output logic [3:0]  an,
    output logic        frame_tick
);

    // Terminal counts of the slot counter in each state.
    localparam logic [15:0] c_blank_last = 16'(BLANK_CYC - 1);
    localparam logic [15:0] c_show_last  = 16'(SHOW_CYC - 1);

    // Scan state encoding.
    localparam logic [0:0] c_st_blank = 1'b0;
    localparam logic [0:0] c_st_show  = 1'b1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [1:0]  r_idx;
    logic [15:0] r_cnt;
    logic [15:0] r_active;
    logic [15:0] r_shadow;
    logic        r_pending;
    logic [3:0]  r_x;
    logic [3:0]  r_an;
    logic        r_frame_tick;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [0:0]  w_state_n;
    logic [1:0]  w_idx_n;
    logic [15:0] w_cnt_n;
    logic        w_boundary;
    logic        w_accept;
    logic [15:0] w_active_n;
    logic [15:0] w_shadow_n;
    logic        w_pending_n;
    logic [3:0]  w_digit_n;
    logic        w_lead_zero;
    logic        w_blank_digit;
    logic [3:0]  w_an_n;
    logic        w_frame_tick_n;

    // Scan sequencing: counter runs within a state and clears on every
    // state change; the digit index advances when a SHOW slot ends.
    always_comb begin
        w_state_n  = r_state;
        w_idx_n    = r_idx;
        w_cnt_n    = r_cnt + 16'd1;
        w_boundary = 1'b0;
        case (r_state)
            c_st_blank: begin
                if (r_cnt == c_blank_last) begin
                    w_state_n = c_st_show;
                    w_cnt_n   = '0;
                end
            end
            default: begin
                if (r_cnt == c_show_last) begin
                    w_state_n  = c_st_blank;
                    w_cnt_n    = '0;
                    w_idx_n    = r_idx + 2'd1;
                    w_boundary = (r_idx == 2'd3);
                end
            end
        endcase
    end

    // Handshake and double buffering. The transfer uses the pending flag as
    // it stands before this edge, so a load accepted in the boundary cycle
    // waits for the next boundary.
    always_comb begin
        w_accept    = load & ~r_pending;
        w_active_n  = (w_boundary & r_pending) ? r_shadow : r_active;
        w_shadow_n  = w_accept ? digits_in : r_shadow;
        w_pending_n = w_accept | (r_pending & ~w_boundary);
    end

    // Output decode is computed from the next-state values and registered,
    // so the outputs line up with the state they describe and never glitch.
    always_comb begin
        case (w_idx_n)
            2'd0:    w_digit_n = w_active_n[3:0];
            2'd1:    w_digit_n = w_active_n[7:4];
            2'd2:    w_digit_n = w_active_n[11:8];
            default: w_digit_n = w_active_n[15:12];
        endcase

        // A digit is a leading zero when it and every digit to its left are
        // zero; the rightmost digit is always shown.
        case (w_idx_n)
            2'd0:    w_lead_zero = 1'b0;
            2'd1:    w_lead_zero = (w_active_n[15:4] == 12'd0);
            2'd2:    w_lead_zero = (w_active_n[15:8] == 8'd0);
            default: w_lead_zero = (w_active_n[15:12] == 4'd0);
        endcase

        w_blank_digit = (w_digit_n > 4'd9) | (lzb & w_lead_zero);

        if ((w_state_n == c_st_show) && !w_blank_digit) begin
            w_an_n = ~(4'b0001 << w_idx_n);
        end else begin
            w_an_n = 4'b1111;
        end

        w_frame_tick_n = (w_state_n == c_st_show) && (w_idx_n == 2'd3) &&
                         (w_cnt_n == c_show_last);
    end

    // ------------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_blank;
            r_idx        <= 2'd0;
            r_cnt        <= 16'd0;
            r_active     <= 16'd0;
            r_shadow     <= 16'd0;
            r_pending    <= 1'b0;
            r_x          <= 4'd0;
            r_an         <= 4'b1111;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_idx        <= w_idx_n;
            r_cnt        <= w_cnt_n;
            r_active     <= w_active_n;
            r_shadow     <= w_shadow_n;
            r_pending    <= w_pending_n;
            r_x          <= w_digit_n;
            r_an         <= w_an_n;
            r_frame_tick <= w_frame_tick_n;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ready      = ~r_pending;
    assign x3         = r_x[3];
    assign x2         = r_x[2];
    assign x1         = r_x[1];
    assign x0         = r_x[0];
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Self-checking bench for seg_scan_ctrl (BLANK_CYC=2,
//               SHOW_CYC=4, 24-cycle frame). Expected outputs come from a
//               frame-position model: cycle t after reset sits at position
//               t mod 24 of the frame, slot = position / 6, and the first two
//               cycles of each slot are dark. Directed scenarios are followed
//               by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int c_blank = 2;
    localparam int c_show  = 4;
    localparam int c_slot  = c_blank + c_show;
    localparam int c_frame = 4 * c_slot;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] digits_in;
    logic        lzb;
    logic        ready;
    logic        x3, x2, x1, x0;
    logic [3:0]  an;
    logic        frame_tick;

    seg_scan_ctrl #(
        .BLANK_CYC(c_blank),
        .SHOW_CYC (c_show)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .digits_in (digits_in),
        .lzb       (lzb),
        .ready     (ready),
        .x3        (x3),
        .x2        (x2),
        .x1        (x1),
        .x0        (x0),
        .an        (an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          t;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    logic        m_pending;
    logic        m_lzb_q;
    logic        cur_lzb;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag);
        int          p;
        int          sl;
        logic [3:0]  dig;
        logic        blk;
        logic        all_zero;
        logic [3:0]  one_hot;
        logic [3:0]  exp_an;
        logic [3:0]  obs_x;
        p   = t % c_frame;
        sl  = p / c_slot;
        dig = m_active[4*sl +: 4];
        blk = (dig > 4'd9);
        if (m_lzb_q && sl != 0) begin
            all_zero = 1'b1;
            for (int k = sl; k < 4; k++) begin
                if (m_active[4*k +: 4] != 4'd0) all_zero = 1'b0;
            end
            blk = blk | all_zero;
        end
        one_hot = 4'b0001 << sl;
        exp_an  = ((p % c_slot) < c_blank || blk) ? 4'b1111 : ~one_hot;
        obs_x   = {x3, x2, x1, x0};

        n_cmp++;
        assert (obs_x === dig) else begin
            n_fail++;
            $error("FAIL %s.x t=%0d observed=%h expected=%h", tag, t, obs_x, dig);
        end
        n_cmp++;
        assert (an === exp_an) else begin
            n_fail++;
            $error("FAIL %s.an t=%0d observed=%b expected=%b", tag, t, an, exp_an);
        end
        n_cmp++;
        assert (frame_tick === (p == c_frame - 1)) else begin
            n_fail++;
            $error("FAIL %s.frame_tick t=%0d observed=%b expected=%b", tag, t,
                   frame_tick, (p == c_frame - 1));
        end
        n_cmp++;
        assert (ready === !m_pending) else begin
            n_fail++;
            $error("FAIL %s.ready t=%0d observed=%b expected=%b", tag, t, ready, !m_pending);
        end
    endtask

    // Apply inputs for the coming edge, advance the model across that edge,
    // then check the following cycle at the falling edge.
    task automatic tick(input logic ld, input logic [15:0] d, input logic lz,
                        input logic r, input string tag);
        logic old_pend;
        load      = ld;
        digits_in = d;
        lzb       = lz;
        rst       = r;
        if (r) begin
            t         = 0;
            m_active  = 16'h0000;
            m_shadow  = 16'h0000;
            m_pending = 1'b0;
        end else begin
            old_pend = m_pending;
            if ((t % c_frame) == c_frame - 1 && old_pend) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            if (ld && !old_pend) begin
                m_shadow  = d;
                m_pending = 1'b1;
            end
            t++;
        end
        m_lzb_q = lz;
        @(posedge clk);
        @(negedge clk);
        check(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0000, cur_lzb, 1'b0, tag);
    endtask

    task automatic idle_until(input int pos, input string tag);
        int guard;
        guard = 0;
        while ((t % c_frame) != pos && guard < c_frame) begin
            tick(1'b0, 16'h0000, cur_lzb, 1'b0, tag);
            guard++;
        end
    endtask

    task automatic rand_value(output logic [15:0] v);
        case ($urandom_range(0, 3))
            0: v = 16'($urandom);
            1: v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                    4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            2: v = {8'h00, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            default: v = {12'h000, 4'($urandom_range(0, 15))};
        endcase
    endtask

    initial begin
        logic [15:0] v;
        logic        ld;
        logic        r;
        load      = 1'b0;
        digits_in = 16'h0000;
        lzb       = 1'b0;
        rst       = 1'b1;
        cur_lzb   = 1'b0;
        t         = 0;
        m_active  = 16'h0000;
        m_shadow  = 16'h0000;
        m_pending = 1'b0;
        m_lzb_q   = 1'b0;

        // Reset, then one idle frame of zeros.
        tick(1'b0, 16'h0000, 1'b0, 1'b1, "reset");
        tick(1'b1, 16'h9999, 1'b0, 1'b1, "reset_over_load");
        idle(c_frame, "idle_frame");

        // Load mid-frame, then a second load while not ready is ignored.
        idle_until(10, "pre_load");
        tick(1'b1, 16'h1234, cur_lzb, 1'b0, "load_1234");
        tick(1'b1, 16'h5678, cur_lzb, 1'b0, "ignored_5678");
        idle(2 * c_frame, "show_1234");

        // Load accepted in the boundary cycle waits for the next boundary.
        idle_until(c_frame - 1, "pre_boundary");
        cur_lzb = 1'b1;
        tick(1'b1, 16'h0070, cur_lzb, 1'b0, "boundary_load");
        idle(2 * c_frame, "lzb_0070");
        cur_lzb = 1'b0;
        idle(c_frame, "nolzb_0070");

        // Invalid BCD digit is dark.
        tick(1'b1, 16'h00A9, cur_lzb, 1'b0, "load_00a9");
        idle(2 * c_frame, "show_00a9");

        // Reset with a pending value in the lit part of digit 2.
        tick(1'b1, 16'h4321, cur_lzb, 1'b0, "load_4321");
        idle_until(2 * c_slot + c_blank, "pre_reset");
        tick(1'b0, 16'h0000, cur_lzb, 1'b1, "reset_recovery");
        idle(c_frame + 6, "after_reset");

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            rand_value(v);
            ld = ($urandom_range(0, 5) == 0);
            r  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) cur_lzb = ~cur_lzb;
            tick(ld, v, cur_lzb, r, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter BLANK_CYC, default 2: blanking cycles per digit slot, legal range 1..65535.
REQ-002 The block SHALL have parameter SHOW_CYC, default 1000: lit cycles per digit slot, legal range 1..65535.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port load, input, 1 bit: request to capture a new 4-digit value.
REQ-006 The block SHALL have port digits_in, input, 16 bits: BCD digits; [15:12] is digit 3 (leftmost), [3:0] is digit 0.
REQ-007 The block SHALL have port lzb, input, 1 bit: leading-zero blanking enable, sampled every cycle.
REQ-008 The block SHALL have port ready, output, 1 bit: high when a load will be accepted.
REQ-009 The block SHALL have port x3, x2, x1, x0, outputs, 1 bit each: BCD code to the shared 7-segment decoder, x3 is the MSB.
REQ-010 The block SHALL have port an, output, 4 bits: active-low digit enables; an[k] selects digit k.
REQ-011 The block SHALL have port frame_tick, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-012 The block SHALL hold an active register (16 bits, shown), a shadow register (16 bits), a pending flag, a 2-bit digit index idx, a 16-bit slot counter and a state in {BLANK, SHOW}; all are registered.
REQ-013 In BLANK, an SHALL be 4'b1111 for exactly BLANK_CYC cycles, and {x3,x2,x1,x0} SHALL equal active digit idx.
REQ-014 In SHOW, {x3,x2,x1,x0} SHALL hold active digit idx for exactly SHOW_CYC cycles, with an[idx]=0 and all other bits 1 unless the digit is blanked.
REQ-015 A digit SHALL be blanked (an=4'b1111 during its SHOW) when its value is >9, or when lzb=1 and it is a leading zero.
REQ-016 Leading-zero rules: digit 3 is blanked if it is 0; digit 2 if digits 3 and 2 are 0; digit 1 if digits 3..1 are 0; digit 0 is never blanked for leading zeros.
REQ-017 Transitions: BLANK to SHOW when the counter reaches BLANK_CYC-1; SHOW to BLANK when the counter reaches SHOW_CYC-1, with idx incremented modulo 4 on that edge; the counter clears on every state change.
REQ-018 One frame SHALL be 4*(BLANK_CYC+SHOW_CYC) cycles, in digit order 0,1,2,3, then wrapping to 0.
REQ-019 Frame boundary = last SHOW cycle of idx 3: frame_tick SHALL be 1 in that cycle only; if pending=1, active takes shadow and pending clears on that edge.
REQ-020 Handshake: ready = NOT pending; load=1 with ready=1 SHALL capture digits_in into shadow and set pending, so ready=0 from the next cycle.
REQ-021 A load while ready=0 SHALL be ignored, with no change to shadow.
REQ-022 A load accepted in the boundary cycle while pending=0 SHALL set pending and be applied at the following boundary, not the current one.
REQ-023 Active SHALL change only at frame boundaries, so no frame ever mixes old and new digits.
REQ-024 x/an SHALL be glitch-free registered outputs, changing only on clk edges.

Reset
REQ-025 With rst=1 at a clk edge: state=BLANK, idx=0, counter=0, active=0, shadow=0, pending=0; outputs an=4'b1111, x=0, ready=1, frame_tick=0.
REQ-026 rst mid-frame or with pending=1 SHALL discard shadow and pending data, with no partial update of active.
REQ-027 rst SHALL override load in the same cycle.
REQ-028 After rst falls, the first SHOW of digit 0 SHALL begin BLANK_CYC cycles later.

Verification (BLANK_CYC=2, SHOW_CYC=4, frame=24 cycles)
REQ-029 Reset scenario: reset, then idle 24 cycles -> an sequence 1111x2, 1110x4, 1111x2, 1101x4, 1111x2, 1011x4, 1111x2, 0111x4; x=0 throughout; frame_tick pulses once at cycle 24.
REQ-030 Load scenario: load 16'h1234 while ready=1 mid-frame -> ready=0 until the boundary; from the next frame, digit0 x=4, digit1 x=3, digit2 x=2, digit3 x=1; ready=1 after the boundary.
REQ-031 Ignored-load scenario: load 16'h1234, then load 16'h5678 while ready=0 -> displayed value is 1234 and 5678 never appears.
REQ-032 Leading-zero scenario: lzb=1 with value 16'h0070 -> digits 3 and 2 dark (an stays 1111 in their SHOW), digit1 shows 7, digit0 shows 0; with lzb=0 all four digits lit.
REQ-033 Invalid-BCD scenario: value 16'h00A9 -> digit1 blanked, digit0 shows 9.
REQ-034 Reset-recovery scenario: rst asserted with pending=1 mid-SHOW of digit 2 -> next cycle an=1111, ready=1, active=0, and the scan restarts at digit 0.
